// File: rtl/router_pkg.sv
// Shared constants and FSM state encoding for the router datapath.
// Imported by the register stage, the parity accumulator and the bench.
package router_pkg;

  localparam int         PKT_DATA_WIDTH   = 8;
  localparam logic [1:0] PKT_ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'b000,
    LOAD_FIRST_DATA    = 3'b001,
    LOAD_DATA          = 3'b010,
    FIFO_FULL_STATE    = 3'b011,
    LOAD_AFTER_FULL    = 3'b100,
    LOAD_PARITY        = 3'b101,
    CHECK_PARITY_ERROR = 3'b110,
    WAIT_TILL_EMPTY    = 3'b111
  } fsm_state_t;

  function automatic logic is_hdr_addr(
    input logic [1:0] addr
  );
    return addr != PKT_ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity, captured packet parity and the mismatch flag
// presented to the FSM after the check strobe.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = PKT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clr,
  input  logic                  i_acc_en,
  input  logic [DATA_WIDTH-1:0] i_acc_data,
  input  logic                  i_ld_en,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  input  logic                  i_chk,
  input  logic                  i_chk_qual,
  input  logic                  i_err_clr,
  output logic                  o_err
);

  logic [DATA_WIDTH-1:0] r_internal_parity;
  logic [DATA_WIDTH-1:0] r_packet_parity;
  logic                  r_err;
  logic                  w_mismatch;

  assign w_mismatch = r_internal_parity != r_packet_parity;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_internal_parity <= '0;
    end else if (i_clr) begin
      r_internal_parity <= '0;
    end else if (i_acc_en) begin
      r_internal_parity <= r_internal_parity ^ i_acc_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_packet_parity <= '0;
    end else if (i_ld_en) begin
      r_packet_parity <= i_ld_data;
    end
  end

  // A mismatch only counts once the parity byte has actually arrived.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end else if (i_chk) begin
      r_err <= i_chk_qual & w_mismatch;
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/router_pkt_reg.sv
// Router datapath register stage: header/hold latches, output byte,
// parity bookkeeping and status flags back to the control FSM.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int         DATA_WIDTH   = PKT_DATA_WIDTH,
  parameter logic [1:0] ADDR_INVALID = PKT_ADDR_INVALID
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_packet_valid,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] r_header_byte;
  logic [DATA_WIDTH-1:0] r_hold_byte;
  logic                  r_parity_done;
  logic                  r_low_pkt_valid;

  logic                  w_lfd;
  logic                  w_ld;
  logic                  w_laf;
  logic                  w_chk;
  logic                  w_hdr_ld;
  logic                  w_hold_ld;
  logic                  w_pp_ld_data;
  logic                  w_pp_ld_hold;
  logic                  w_pp_ld;
  logic [DATA_WIDTH-1:0] w_pp_data;
  logic                  w_acc_en;
  logic [DATA_WIDTH-1:0] w_acc_data;
  logic [DATA_WIDTH-1:0] w_dout_nxt;
  logic                  w_err;

  // Priority lfd > ld > laf > rst_int_reg guards against overlap.
  assign w_lfd = lfd_state;
  assign w_ld  = ld_state & ~lfd_state;
  assign w_laf = laf_state & ~lfd_state & ~ld_state;
  assign w_chk = rst_int_reg & ~lfd_state & ~ld_state & ~laf_state;

  assign w_hdr_ld  = detect_add & pkt_valid
                   & (data_in[1:0] != ADDR_INVALID);
  assign w_hold_ld = w_ld & fifo_full;

  assign w_pp_ld_data = w_ld & ~pkt_valid & ~fifo_full;
  assign w_pp_ld_hold = w_laf & r_low_pkt_valid & ~r_parity_done;
  assign w_pp_ld      = w_pp_ld_data | w_pp_ld_hold;
  assign w_pp_data    = w_pp_ld_data ? data_in : r_hold_byte;

  assign w_acc_en   = w_lfd | (w_ld & pkt_valid);
  assign w_acc_data = w_lfd ? r_header_byte : data_in;

  always_comb begin
    w_dout_nxt = r_dout;
    if (w_lfd) begin
      w_dout_nxt = r_header_byte;
    end else if (w_ld && !fifo_full) begin
      w_dout_nxt = data_in;
    end else if (w_laf) begin
      w_dout_nxt = r_hold_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
    end else begin
      r_dout <= w_dout_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_header_byte <= '0;
    end else if (w_hdr_ld) begin
      r_header_byte <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold_byte <= '0;
    end else if (w_hold_ld) begin
      r_hold_byte <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_parity_done <= 1'b0;
    end else if (w_pp_ld) begin
      r_parity_done <= 1'b1;
    end else if (detect_add) begin
      r_parity_done <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      r_low_pkt_valid <= 1'b0;
    end else if (w_ld && !pkt_valid) begin
      r_low_pkt_valid <= 1'b1;
    end
  end

  router_parity_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .clock      (clock),
    .reset      (reset),
    .i_clr      (detect_add),
    .i_acc_en   (w_acc_en),
    .i_acc_data (w_acc_data),
    .i_ld_en    (w_pp_ld),
    .i_ld_data  (w_pp_data),
    .i_chk      (w_chk),
    .i_chk_qual (r_parity_done),
    .i_err_clr  (w_lfd),
    .o_err      (w_err)
  );

  assign dout             = r_dout;
  assign parity_done      = r_parity_done;
  assign low_packet_valid = r_low_pkt_valid;
  assign err              = w_err;

  a_strobe_onehot : assert property (
    @(posedge clock) disable iff (reset)
    $onehot0({lfd_state, ld_state, laf_state,
              full_state, rst_int_reg})
  );

endmodule

// File: tb/tb_router_pkt_reg.sv
// Directed packet scenarios for router_pkt_reg with a queue scoreboard
// and an independent monitor sampling just after each rising edge.
module tb_router_pkt_reg;
  import router_pkg::*;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_packet_valid;
  logic       err;

  typedef struct {
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  event mon_ev;

  router_pkt_reg dut (
    .clock            (clock),
    .reset            (reset),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .dout             (dout),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .err              (err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      ->mon_ev;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(mon_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if ({dout, parity_done, low_packet_valid, err} !==
            {e.dout, e.pd, e.lpv, e.err}) begin
          n_bad++;
          $display("FAIL %s: got dout=%h pd=%b lpv=%b err=%b, want dout=%h pd=%b lpv=%b err=%b",
                   e.nm, dout, parity_done, low_packet_valid, err,
                   e.dout, e.pd, e.lpv, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    pkt_valid   = 1'b0;
    data_in     = 8'h00;
    fifo_full   = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pd,
                          input logic lpv, input logic er,
                          input string nm);
    exp_t e;
    e.dout = d;
    e.pd   = pd;
    e.lpv  = lpv;
    e.err  = er;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  task automatic cyc(input fsm_state_t st, input logic pv,
                     input logic [7:0] d, input logic ff,
                     input logic [7:0] e_d, input logic e_pd,
                     input logic e_lpv, input logic e_err,
                     input string nm, input logic da_f = 1'b0);
    @(negedge clock);
    pkt_valid   = pv;
    data_in     = d;
    fifo_full   = ff;
    detect_add  = (st == DECODE_ADDRESS) | da_f;
    lfd_state   = st == LOAD_FIRST_DATA;
    ld_state    = st == LOAD_DATA;
    laf_state   = st == LOAD_AFTER_FULL;
    full_state  = st == FIFO_FULL_STATE;
    rst_int_reg = st == CHECK_PARITY_ERROR;
    push_exp(e_d, e_pd, e_lpv, e_err, nm);
  endtask

  task automatic async_reset_check(input string nm);
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    #1;
    push_exp(8'h00, 1'b0, 1'b0, 1'b0, nm);
    ->mon_ev;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    push_exp(8'h00, 1'b0, 1'b0, 1'b0, "reset_state");
    ->mon_ev;
    @(negedge clock);
    reset = 1'b0;

    // good packet 05 / 11 22 / parity 36
    cyc(DECODE_ADDRESS,     1, 8'h05, 0, 8'h00, 0, 0, 0, "p1_da");
    cyc(LOAD_FIRST_DATA,    1, 8'h11, 0, 8'h05, 0, 0, 0, "p1_hdr");
    cyc(LOAD_DATA,          1, 8'h11, 0, 8'h11, 0, 0, 0, "p1_b1");
    cyc(LOAD_DATA,          1, 8'h22, 0, 8'h22, 0, 0, 0, "p1_b2");
    cyc(LOAD_DATA,          0, 8'h36, 0, 8'h36, 1, 1, 0, "p1_par");
    cyc(LOAD_PARITY,        0, 8'h00, 0, 8'h36, 1, 1, 0, "p1_lp");
    cyc(CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h36, 1, 0, 0, "p1_chk");
    cyc(WAIT_TILL_EMPTY,    0, 8'h00, 0, 8'h36, 1, 0, 0, "p1_wait");

    // bad parity 37 -> err held until next header
    cyc(DECODE_ADDRESS,     1, 8'h05, 0, 8'h36, 0, 0, 0, "p2_da");
    cyc(LOAD_FIRST_DATA,    1, 8'h11, 0, 8'h05, 0, 0, 0, "p2_hdr");
    cyc(LOAD_DATA,          1, 8'h11, 0, 8'h11, 0, 0, 0, "p2_b1");
    cyc(LOAD_DATA,          1, 8'h22, 0, 8'h22, 0, 0, 0, "p2_b2");
    cyc(LOAD_DATA,          0, 8'h37, 0, 8'h37, 1, 1, 0, "p2_par");
    cyc(CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h37, 1, 0, 1, "p2_err");
    cyc(WAIT_TILL_EMPTY,    0, 8'h00, 0, 8'h37, 1, 0, 1, "p2_err_hold");
    cyc(DECODE_ADDRESS,     1, 8'h06, 0, 8'h37, 0, 0, 1, "p2_err_da");

    // fifo full mid payload: AA diverted, counted once
    cyc(LOAD_FIRST_DATA,    1, 8'hAA, 0, 8'h06, 0, 0, 0, "p3_err_clr");
    cyc(LOAD_DATA,          1, 8'hAA, 1, 8'h06, 0, 0, 0, "p3_full_ld");
    cyc(FIFO_FULL_STATE,    1, 8'hAA, 1, 8'h06, 0, 0, 0, "p3_full_hold");
    cyc(LOAD_AFTER_FULL,    1, 8'hAA, 0, 8'hAA, 0, 0, 0, "p3_laf");
    cyc(LOAD_DATA,          1, 8'hBB, 0, 8'hBB, 0, 0, 0, "p3_b2");
    cyc(LOAD_DATA,          0, 8'h17, 0, 8'h17, 1, 1, 0, "p3_par");
    cyc(CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h17, 1, 0, 0, "p3_chk");

    // parity byte 5C diverted while full
    cyc(DECODE_ADDRESS,     1, 8'h09, 0, 8'h17, 0, 0, 0, "p4_da");
    cyc(LOAD_FIRST_DATA,    1, 8'h55, 0, 8'h09, 0, 0, 0, "p4_hdr");
    cyc(LOAD_DATA,          1, 8'h55, 0, 8'h55, 0, 0, 0, "p4_b1");
    cyc(LOAD_DATA,          0, 8'h5C, 1, 8'h55, 0, 1, 0, "p4_par_full");
    cyc(FIFO_FULL_STATE,    0, 8'h5C, 1, 8'h55, 0, 1, 0, "p4_full");
    cyc(LOAD_AFTER_FULL,    0, 8'h00, 0, 8'h5C, 1, 1, 0, "p4_laf_par");
    cyc(CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h5C, 1, 0, 0, "p4_chk");

    // invalid address 11: header keeps 09, parity state cleared
    cyc(DECODE_ADDRESS,     1, 8'h03, 0, 8'h5C, 0, 0, 0, "p5_bad_addr");
    cyc(LOAD_FIRST_DATA,    1, 8'h00, 0, 8'h09, 0, 0, 0, "p5_hdr_kept");
    cyc(LOAD_DATA,          0, 8'h09, 0, 8'h09, 1, 1, 0, "p5_par");
    cyc(CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h09, 1, 0, 0, "p5_ip_clr");

    // parity_done set beats detect_add clear
    cyc(LOAD_DATA,          0, 8'h42, 0, 8'h42, 1, 1, 0, "pd_set_prio", 1'b1);
    cyc(CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h42, 1, 0, 1, "pd_prio_err");

    // reset in the middle of a payload
    cyc(DECODE_ADDRESS,     1, 8'h05, 0, 8'h42, 0, 0, 1, "p6_da");
    cyc(LOAD_FIRST_DATA,    1, 8'h11, 0, 8'h05, 0, 0, 0, "p6_hdr");
    cyc(LOAD_DATA,          1, 8'h11, 0, 8'h11, 0, 0, 0, "p6_b1");
    cyc(LOAD_DATA,          1, 8'h22, 0, 8'h22, 0, 0, 0, "p6_b2");
    cyc(LOAD_DATA,          1, 8'h33, 0, 8'h33, 0, 0, 0, "p6_b3");
    async_reset_check("mid_pkt_async_reset");
    cyc(LOAD_FIRST_DATA,    0, 8'h77, 0, 8'h00, 0, 0, 0, "hdr_cleared");

    // clean packet after reset
    cyc(DECODE_ADDRESS,     1, 8'h04, 0, 8'h00, 0, 0, 0, "p7_da");
    cyc(LOAD_FIRST_DATA,    1, 8'h10, 0, 8'h04, 0, 0, 0, "p7_hdr");
    cyc(LOAD_DATA,          1, 8'h10, 0, 8'h10, 0, 0, 0, "p7_b1");
    cyc(LOAD_DATA,          0, 8'h14, 0, 8'h14, 1, 1, 0, "p7_par");
    cyc(CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h14, 1, 0, 0, "p7_chk");

    @(negedge clock);
    idle_inputs();
    repeat (2) @(negedge clock);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending entries, want 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
